// File: rtl/apb_sram_pkg.sv
// rtl/apb_sram_pkg.sv - shared types and helpers for the APB SRAM slave
//
// Purpose : FSM state encoding, wait-counter width and strobe-width helper
//           used by apb_sram and sram_bwe.
// Ports   : none (package).
// Options : none here; apb_sram honours APB_SRAM_SLVERR_EN.
package apb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } sram_state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_bwe.sv
// rtl/sram_bwe.sv - single-port synchronous RAM with byte write enables
//
// Purpose : Plain storage array with no bus logic, so a technology macro
//           can be dropped in with the same port list.
// Ports   : clk   - clock, rising edge
//           en    - access enable for this cycle
//           wr    - 1 = write lanes selected by be, 0 = read
//           be    - byte-lane write enables (ignored on reads)
//           addr  - word index
//           wdata - write data
//           rdata - registered read data; changes only on enabled reads
// Options : none.
module sram_bwe
  import apb_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int NB    = strb_w(DATA_W),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // With a non-power-of-two depth the index can name rows that do not exist.
  if (DEPTH == (1 << IDX_W)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (32'(addr) < 32'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i] && in_range) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= in_range ? mem[addr] : 'x;
      end
    end
  end

endmodule

// File: rtl/apb_sram.sv
// rtl/apb_sram.sv - APB3 slave SRAM with byte strobes, wait states and error response
//
// Purpose : APB3 memory slave; FSM, wait counter, range check, PREADY /
//           PSLVERR registers and PRDATA hold logic around sram_bwe.
// Ports   : PCLK, PRESET (async, active-high)
//           PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB - APB request
//           PRDATA, PREADY, PSLVERR                      - APB response
// Options : APB_SRAM_SLVERR_EN - when defined, word indices >= DEPTH are
//           rejected with PSLVERR=1 and PRDATA=0; when undefined PSLVERR
//           is 0 and the index wraps modulo 2**$clog2(DEPTH).
module apb_sram
  import apb_sram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 0
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [DATA_W-1:0]           PWDATA,
  input  logic [strb_w(DATA_W)-1:0]   PSTRB,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR
);

  localparam int NB    = strb_w(DATA_W);
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
    $error("apb_sram: WAIT_CYC must be within 0..15");
  end
  if (DATA_W < 8 || DATA_W > 64 || (DATA_W % 8) != 0) begin : g_bad_width
    $error("apb_sram: DATA_W must be a multiple of 8 within 8..64");
  end

  sram_state_e           state;
  sram_state_e           next_state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] cnt_next;
  logic                  access;
  logic                  in_range;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  prdata_sel;
  logic                  unused_addr;

  // Byte-offset bits (and wrapped-away index bits) are intentionally ignored.
  assign unused_addr = ^PADDR;
  assign ram_addr    = PADDR[LSB +: IDX_W];

`ifdef APB_SRAM_SLVERR_EN
  assign in_range = (32'(PADDR[ADDR_W-1:LSB]) < 32'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (PSEL && PENABLE) begin
          if (WAIT_CYC == 0) begin
            next_state = RESP;
          end else begin
            cnt_next   = WAIT_CNT_W'(WAIT_CYC - 1);
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it silently.
          cnt_next   = '0;
          next_state = IDLE;
        end else if (cnt == '0) begin
          next_state = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        // Leave unconditionally so a held PSEL&&PENABLE cannot re-trigger.
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The memory is touched only on the edge that enters RESP; PRESET gates it
  // because the RAM itself has no reset and would otherwise still fire.
  assign access = (next_state == RESP) && (state != RESP) && !PRESET;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      PREADY     <= 1'b0;
      prdata_sel <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_next;
      PREADY <= (next_state == RESP);
      // Writes leave the selector alone so PRDATA keeps the last read word.
      if (access && !PWRITE) begin
        prdata_sel <= in_range;
      end
    end
  end

`ifdef APB_SRAM_SLVERR_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSLVERR <= 1'b0;
    end else begin
      PSLVERR <= access && !in_range;
    end
  end
`else
  assign PSLVERR = 1'b0;
`endif

  // RAM rdata only moves on in-range reads, so selecting it holds the value.
  assign PRDATA = prdata_sel ? ram_rdata : '0;

  sram_bwe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (PCLK),
    .en    (access && in_range),
    .wr    (PWRITE),
    .be    (PSTRB),
    .addr  (ram_addr),
    .wdata (PWDATA),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/apb_sram.md
# apb_sram

Parametrised APB3 slave SRAM with byte-lane write strobes, configurable wait states and an error response for out-of-range accesses. It replaces the fixed 32-bit/1 KiW data RAM on the SoC APB bus and serves as the common on-chip memory slave for any width or depth the address decoder assigns.

## Interface
- `DATA_W`, 32: data bus width; multiple of 8, range 8..64.
- `DEPTH`, 1024: number of words; need not be a power of two.
- `ADDR_W`, 12: PADDR width; must satisfy `2**ADDR_W >= DEPTH*DATA_W/8`.
- `WAIT_CYC`, 0: extra wait states inserted before PREADY, range 0..15.
- `PCLK` input 1: clock, all logic on rising edge.
- `PRESET` input 1: asynchronous, active-high reset.
- `PADDR` input ADDR_W: byte address; word index = `PADDR[ADDR_W-1:$clog2(DATA_W/8)]`; low bits ignored.
- `PSEL` input 1: slave select.
- `PENABLE` input 1: access phase.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PWDATA` input DATA_W: write data.
- `PSTRB` input DATA_W/8: byte-lane write enables; ignored on reads.
- `PRDATA` output DATA_W: read data.
- `PREADY` output 1: transfer complete.
- `PSLVERR` output 1: error response, valid only while PREADY=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on `PSEL && PENABLE` -> RESP if WAIT_CYC=0, else load counter with WAIT_CYC-1 and go to WAIT.
- WAIT: decrement counter each cycle; at 0 -> RESP. If PSEL drops (protocol violation) -> IDLE, no memory access, no response.
- RESP: PREADY=1 for exactly one cycle; unconditionally -> IDLE. This prevents a second access while the master still holds `PSEL && PENABLE` on the completing edge.
- Memory access is performed on the clock edge that enters RESP, using the PADDR/PWRITE/PWDATA/PSTRB sampled on that edge.
- Write: each lane i where `PSTRB[i]=1` updates byte i. `PSTRB=0` is a legal no-op write that still completes with PREADY.
- Read: PRDATA is loaded with the full word. PRDATA holds its value until the next read completes; writes never change it.
- Out of range (word index >= DEPTH): no write is performed, PRDATA is loaded with 0, and PSLVERR=1 during RESP (see Configuration).
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, counter=0.
- Latency from the first cycle with `PSEL && PENABLE` to PREADY high is WAIT_CYC+1 cycles. With WAIT_CYC=0, a transfer takes 3 cycles: setup, access, access+PREADY.
- Back-to-back transfers: a setup phase may follow RESP immediately; no idle cycle is required.
- PSLVERR is asserted and deasserted together with PREADY; it is 0 whenever PREADY=0.
- PRESET asserted mid-transfer:
  - The FSM returns to IDLE asynchronously and the outputs take their reset values.
  - A write whose RESP edge has not occurred is not performed.
  - A write already performed stays in memory.
- Counter width is 4 bits. WAIT_CYC outside 0..15 is a compile-time error via an elaboration assertion.

## Configuration
- `APB_SRAM_SLVERR_EN` defined:
  - Out-of-range accesses are detected and reported with PSLVERR=1 and PRDATA=0, with no write.
- `APB_SRAM_SLVERR_EN` undefined:
  - PSLVERR is tied to 0.
  - The range comparator is removed and the word index is taken modulo `2**$clog2(DEPTH)`.
  - A resulting index >= DEPTH (non-power-of-two DEPTH only) reads X and its writes are dropped.

## Structure
- Package `apb_sram_pkg`:
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP} sram_state_e`.
  - Constant `WAIT_CNT_W = 4`.
  - Function `strb_w(data_w)` returning data_w/8.
- Sub-module `sram_bwe`: a single-port synchronous array with per-byte write enable and registered read data, parameters DATA_W and DEPTH.
  - It contains no APB logic, so a technology macro can replace it.
- The top level holds the FSM, wait counter, range check, PREADY/PSLVERR registers and the PRDATA hold logic.

## Test plan
- Reset, then write 0xDEADBEEF to 0x010 with PSTRB=4'hF and read 0x010 -> PRDATA=0xDEADBEEF; PREADY high for exactly one cycle per transfer; PSLVERR=0.
- Write 0xAABBCCDD to 0x020 with PSTRB=4'hF, then write 0x11223344 with PSTRB=4'b0101 -> read returns 0xAA22CC44.
- WAIT_CYC=3, read -> PREADY rises exactly 4 cycles after the first `PSEL && PENABLE` cycle; a read followed by a write returns to IDLE with no double write.
- DEPTH=1000 with `APB_SRAM_SLVERR_EN` defined, write to byte address 0xFA0 (index 1000) -> PSLVERR=1 with PREADY and no memory change; a read there returns PRDATA=0 with PSLVERR=1.
- Assert PRESET during WAIT of a write (WAIT_CYC=2) -> PREADY=0 and PRDATA=0 immediately; a subsequent read of that address returns the old contents.
- Back-to-back reads of 0x000 and 0x004 with no idle cycle -> both complete and return the correct data; PRDATA holds 0x004's data through a following write.
